// File: rtl/rs_generic.sv
// Generic reservation station: N_ENT entries that wait for operand tags on the CDB,
// dispatch the oldest ready entry to a functional unit, and free on their own tag's broadcast.
module rs_generic #(
   parameter int N_ENT    = 4,
   parameter int DATA_W   = 64,
   parameter int TAG_W    = 4,
   parameter int ROB_W    = 2,
   parameter int OPC_W    = 6,
   parameter int BASE_TAG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   output logic [TAG_W-1:0]  issue_rs_tag,
   input  logic [OPC_W-1:0]  issue_opcode,
   input  logic [TAG_W-1:0]  issue_tag1,
   input  logic [TAG_W-1:0]  issue_tag2,
   input  logic [DATA_W-1:0] issue_op1,
   input  logic [DATA_W-1:0] issue_op2,
   input  logic [DATA_W-1:0] issue_incr_pc,
   input  logic [DATA_W-1:0] issue_offset,
   input  logic [ROB_W-1:0]  issue_rob,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              disp_valid,
   input  logic              disp_ready,
   output logic [OPC_W-1:0]  disp_opcode,
   output logic [DATA_W-1:0] disp_a,
   output logic [DATA_W-1:0] disp_b,
   output logic [DATA_W-1:0] disp_incr_pc,
   output logic [DATA_W-1:0] disp_offset,
   output logic [ROB_W-1:0]  disp_rob,
   output logic [TAG_W-1:0]  disp_tag,
   output logic [$clog2(N_ENT+1)-1:0] count
);

   localparam int CNT_W = $clog2(N_ENT+1);
   localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

   if (N_ENT < 2 || N_ENT > 8 || BASE_TAG < 1 || (BASE_TAG + N_ENT - 1) >= (1 << TAG_W)) begin : g_badParam
      $error("rs_generic: illegal N_ENT/BASE_TAG/TAG_W combination");
   end

   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} entState_t;

   entState_t          r_state  [N_ENT];
   logic [OPC_W-1:0]   r_opcode [N_ENT];
   logic [TAG_W-1:0]   r_tag1   [N_ENT];
   logic [TAG_W-1:0]   r_tag2   [N_ENT];
   logic [DATA_W-1:0]  r_op1    [N_ENT];
   logic [DATA_W-1:0]  r_op2    [N_ENT];
   logic [DATA_W-1:0]  r_incrPc [N_ENT];
   logic [DATA_W-1:0]  r_offset [N_ENT];
   logic [ROB_W-1:0]   r_rob    [N_ENT];
   // r_older[i][j] is set when entry i was issued before entry j
   logic [N_ENT-1:0]   r_older  [N_ENT];
   logic               r_holdValid;
   logic [IDX_W-1:0]   r_holdIdx;

   logic               w_freeFound;
   logic [IDX_W-1:0]   w_freeIdx;
   logic [CNT_W-1:0]   w_count;
   logic [N_ENT-1:0]   w_ready;
   logic [N_ENT-1:0]   w_isOldest;
   logic               w_readyFound;
   logic [IDX_W-1:0]   w_oldestIdx;
   logic [IDX_W-1:0]   w_selIdx;
   logic               w_issueFire;
   logic               w_dispFire;
   logic               w_hit1;
   logic               w_hit2;

   always_comb begin
      w_freeFound  = 1'b0;
      w_freeIdx    = '0;
      w_count      = '0;
      w_ready      = '0;
      w_isOldest   = '0;
      w_readyFound = 1'b0;
      w_oldestIdx  = '0;
      for (int i = N_ENT - 1; i >= 0; i--) begin
         if (r_state[i] == ST_FREE) begin
            w_freeFound = 1'b1;
            w_freeIdx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < N_ENT; i++) begin
         if (r_state[i] != ST_FREE) w_count = w_count + CNT_W'(1);
         w_ready[i] = (r_state[i] == ST_READY);
      end
      for (int i = 0; i < N_ENT; i++) begin
         w_isOldest[i] = w_ready[i];
         for (int j = 0; j < N_ENT; j++) begin
            if (j != i && w_ready[j] && !r_older[i][j]) w_isOldest[i] = 1'b0;
         end
      end
      for (int i = N_ENT - 1; i >= 0; i--) begin
         if (w_isOldest[i]) begin
            w_readyFound = 1'b1;
            w_oldestIdx  = IDX_W'(i);
         end
      end
   end

   // A stalled offer stays pinned to its entry until the FU takes it
   assign w_selIdx    = r_holdValid ? r_holdIdx : w_oldestIdx;
   assign disp_valid  = r_holdValid | w_readyFound;
   assign w_dispFire  = disp_valid & disp_ready;
   assign w_issueFire = issue_valid & w_freeFound;
   assign w_hit1      = cdb_valid && (cdb_tag != '0) && (issue_tag1 == cdb_tag);
   assign w_hit2      = cdb_valid && (cdb_tag != '0) && (issue_tag2 == cdb_tag);

   assign issue_ready  = w_freeFound;
   assign issue_rs_tag = w_freeFound ? TAG_W'(BASE_TAG + int'(w_freeIdx)) : '0;
   assign count        = w_count;

   always_comb begin
      disp_opcode  = '0;
      disp_a       = '0;
      disp_b       = '0;
      disp_incr_pc = '0;
      disp_offset  = '0;
      disp_rob     = '0;
      disp_tag     = '0;
      if (disp_valid) begin
         disp_opcode  = r_opcode[w_selIdx];
         disp_a       = r_op1[w_selIdx];
         disp_b       = r_op2[w_selIdx];
         disp_incr_pc = r_incrPc[w_selIdx];
         disp_offset  = r_offset[w_selIdx];
         disp_rob     = r_rob[w_selIdx];
         disp_tag     = TAG_W'(BASE_TAG + int'(w_selIdx));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ENT; i++) begin
            r_state[i]  <= ST_FREE;
            r_opcode[i] <= '0;
            r_tag1[i]   <= '0;
            r_tag2[i]   <= '0;
            r_op1[i]    <= '0;
            r_op2[i]    <= '0;
            r_incrPc[i] <= '0;
            r_offset[i] <= '0;
            r_rob[i]    <= '0;
            r_older[i]  <= '0;
         end
         r_holdValid <= 1'b0;
         r_holdIdx   <= '0;
      end else if (flush) begin
         for (int i = 0; i < N_ENT; i++) r_state[i] <= ST_FREE;
         r_holdValid <= 1'b0;
      end else begin
         for (int i = 0; i < N_ENT; i++) begin
            case (r_state[i])
               ST_FREE: begin
                  if (w_issueFire && w_freeIdx == IDX_W'(i)) begin
                     r_opcode[i] <= issue_opcode;
                     r_tag1[i]   <= w_hit1 ? '0 : issue_tag1;
                     r_tag2[i]   <= w_hit2 ? '0 : issue_tag2;
                     r_op1[i]    <= w_hit1 ? cdb_data : issue_op1;
                     r_op2[i]    <= w_hit2 ? cdb_data : issue_op2;
                     r_incrPc[i] <= issue_incr_pc;
                     r_offset[i] <= issue_offset;
                     r_rob[i]    <= issue_rob;
                     r_state[i]  <= ((w_hit1 || issue_tag1 == '0) && (w_hit2 || issue_tag2 == '0))
                                    ? ST_READY : ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (cdb_valid && cdb_tag != '0 && r_tag1[i] == cdb_tag) begin
                     r_tag1[i] <= '0;
                     r_op1[i]  <= cdb_data;
                  end
                  if (cdb_valid && cdb_tag != '0 && r_tag2[i] == cdb_tag) begin
                     r_tag2[i] <= '0;
                     r_op2[i]  <= cdb_data;
                  end
                  if (r_tag1[i] == '0 && r_tag2[i] == '0) r_state[i] <= ST_READY;
               end
               ST_READY: begin
                  if (w_dispFire && w_selIdx == IDX_W'(i)) r_state[i] <= ST_EXEC;
               end
               ST_EXEC: begin
                  if (cdb_valid && cdb_tag == TAG_W'(BASE_TAG + i)) r_state[i] <= ST_FREE;
               end
               default: r_state[i] <= ST_FREE;
            endcase
         end
         if (w_issueFire) begin
            for (int j = 0; j < N_ENT; j++) r_older[j][w_freeIdx] <= 1'b1;
            r_older[w_freeIdx] <= '0;
         end
         r_holdValid <= disp_valid & ~disp_ready;
         r_holdIdx   <= w_selIdx;
      end
   end

endmodule
